ins_fetcher: RTL and testbench
==============================

# ins_fetcher

Instruction fetch unit: sequences the PC, fetches 32-bit instructions over the memory-controller handshake, and pre-decodes control flow. It is the requesting side of the branch-predictor protocol: it asks for a taken/not-taken verdict on every conditional branch and hands the predictor both candidate addresses. It redirects the PC on a predictor flush and delivers one instruction at a time, with its PC and predicted direction, to the decode/issue stage.

## Interface
- RESET_PC, 32'h0, PC value loaded on reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- mem_req  out  1  fetch request, held until mem_valid
- mem_addr  out  32  fetch address (PC)
- mem_valid  in  1  one-cycle pulse, mem_data valid
- mem_data  in  32  fetched instruction
- ask_predictor  out  1  one-cycle query pulse, conditional branches only
- now_ins_addr  out  32  PC of the queried branch
- jump_addr_to_pred  out  32  PC + B-immediate
- next_addr_to_pred  out  32  PC + 4
- pred_jump  in  1  predictor verdict, valid with predictor_sgn_rdy
- predictor_sgn_rdy  in  1  verdict-valid pulse
- predictor_full  in  1  predictor FIFO full; no query may be issued
- if_flush  in  1  redirect request
- addr_to_if  in  32  redirect target, valid with if_flush
- issue_full  in  1  downstream cannot accept
- ins_valid  out  1  one-cycle pulse, instruction delivered
- ins_out  out  32  instruction word
- ins_pc  out  32  its PC
- ins_pred_jump  out  1  predicted taken (JAL always 1)
- jalr_done  in  1  JALR target resolved
- jalr_target  in  32  resolved JALR target

## Operation
- States: FETCH, WAIT_MEM, WAIT_PRED, WAIT_JALR, DRAIN.
- FETCH: if !issue_full, assert mem_req, drive mem_addr = pc, go to WAIT_MEM; otherwise stay.
- WAIT_MEM: on mem_valid, latch the word and decode opcode [6:0]:
  - 1100011 (branch): if !predictor_full, pulse ask_predictor with now_ins_addr = pc, jump_addr_to_pred = pc + sext(B-imm), next_addr_to_pred = pc + 4, then go to WAIT_PRED. If predictor_full, hold the word and retry the query each cycle until not full.
  - 1101111 (JAL): deliver with ins_pred_jump = 1, pc <= pc + sext(J-imm), go to FETCH.
  - 1100111 (JALR): deliver, go to WAIT_JALR.
  - Any other opcode: deliver, pc <= pc + 4, go to FETCH.
- WAIT_PRED: on predictor_sgn_rdy, deliver with ins_pred_jump = pred_jump; pc <= pred_jump ? jump target : pc + 4; go to FETCH.
- WAIT_JALR: on jalr_done, pc <= jalr_target & ~1, go to FETCH.
- Delivery: pulse ins_valid with ins_out/ins_pc/ins_pred_jump registered in the same edge. Delivery occurs only when issue_full was low at request time; the downstream reserves one slot.
- Flush: has priority over every event in the same cycle.
  - pc <= addr_to_if; ins_valid and ask_predictor are forced to 0.
  - From WAIT_MEM with no mem_valid in that cycle: drop mem_req and go to DRAIN. DRAIN swallows the next mem_valid, then goes to FETCH.
  - From WAIT_MEM with mem_valid in the same cycle: the word is discarded and the next state is FETCH.
  - From all other states: next state is FETCH.
- Address arithmetic is 32-bit modulo 2^32; wrap-around is not trapped.

## Timing
- Reset values: state FETCH, pc = RESET_PC. mem_req, ask_predictor, ins_valid, ins_pred_jump are 0; mem_addr, now_ins_addr, jump_addr_to_pred, next_addr_to_pred, ins_out, ins_pc are 0.
- Reset mid-transaction discards everything; a late mem_valid after reset is ignored, because the unit is in FETCH with no request outstanding.
- Non-branch instruction: mem_valid at cycle t -> ins_valid at t+1, next mem_req at t+1.
- Branch: mem_valid at t -> ask_predictor at t+1, verdict at t+2 -> ins_valid and new pc at t+3.
- ask_predictor is never high for two consecutive cycles, and never while predictor_full is sampled high.
- rdy low: no state change; pulses are not re-issued, and a pulse already high holds its value.

## Test plan
- Reset, RESET_PC=0, memory returns addi -> mem_addr 0, then 4, then 8; ins_valid once per word with ins_pc 0, 4, 8.
- Branch at pc 0x10 with imm +0x20, pred_jump=1 -> now_ins_addr 0x10, jump_addr_to_pred 0x30, next_addr_to_pred 0x14; ins_pred_jump 1; next mem_addr 0x30. With pred_jump=0, next mem_addr 0x14.
- Branch fetched while predictor_full=1 for 3 cycles -> no ask_predictor during those cycles; a single ask on the first cycle full is low.
- if_flush (addr_to_if=0x100) during WAIT_MEM, mem_valid 2 cycles later -> that word is not delivered; next mem_addr 0x100.
- if_flush in the same cycle as predictor_sgn_rdy -> no ins_valid; pc 0x100.
- JAL at 0x40 with imm -8 -> ins_pred_jump 1, next mem_addr 0x38. JALR -> no fetch until jalr_done with target 0x201 -> mem_addr 0x200.

Source files
------------

// File: rtl/ins_fetcher_if.sv
// Bus bundle of the instruction fetch unit: memory handshake, branch-predictor
// query/verdict, flush/JALR redirect and the delivery port towards decode/issue.
interface ins_fetcher_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        ask_predictor;
   logic [31:0] now_ins_addr;
   logic [31:0] jump_addr_to_pred;
   logic [31:0] next_addr_to_pred;
   logic        pred_jump;
   logic        predictor_sgn_rdy;
   logic        predictor_full;
   logic        if_flush;
   logic [31:0] addr_to_if;
   logic        issue_full;
   logic        ins_valid;
   logic [31:0] ins_out;
   logic [31:0] ins_pc;
   logic        ins_pred_jump;
   logic        jalr_done;
   logic [31:0] jalr_target;

   modport master (
      output mem_req, mem_addr, ask_predictor, now_ins_addr, jump_addr_to_pred,
             next_addr_to_pred, ins_valid, ins_out, ins_pc, ins_pred_jump,
      input  mem_valid, mem_data, pred_jump, predictor_sgn_rdy, predictor_full,
             if_flush, addr_to_if, issue_full, jalr_done, jalr_target
   );

   modport slave (
      input  mem_req, mem_addr, ask_predictor, now_ins_addr, jump_addr_to_pred,
             next_addr_to_pred, ins_valid, ins_out, ins_pc, ins_pred_jump,
      output mem_valid, mem_data, pred_jump, predictor_sgn_rdy, predictor_full,
             if_flush, addr_to_if, issue_full, jalr_done, jalr_target
   );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetch unit: PC sequencing, memory fetch handshake, branch
// prediction query, flush/JALR redirect and single-instruction delivery.
module ins_fetcher #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic           clk,
   input logic           rst,
   input logic           rdy,
   ins_fetcher_if.master bus
);
   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      WAIT_MEM  = 3'd1,
      WAIT_PRED = 3'd2,
      WAIT_JALR = 3'd3,
      DRAIN     = 3'd4
   } state_t;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   function automatic logic [31:0] b_imm(input logic [31:0] w);
      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] j_imm(input logic [31:0] w);
      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
   endfunction

   state_t      state_r, state_c, state_nx;
   logic [31:0] pc_r, pc_nx;
   logic [31:0] ins_r, ins_nx;
   logic        hold_r, hold_nx;
   logic        mem_req_r, mem_req_c, mem_req_nx;
   logic [31:0] mem_addr_r, mem_addr_c, mem_addr_nx;
   logic        ask_r, ask_nx;
   logic [31:0] now_addr_r, now_addr_nx;
   logic [31:0] jump_addr_r, jump_addr_nx;
   logic [31:0] next_addr_r, next_addr_nx;
   logic        ins_valid_r, ins_valid_nx;
   logic [31:0] ins_out_r, ins_out_nx;
   logic [31:0] ins_pc_r, ins_pc_nx;
   logic        pred_r, pred_nx;
   logic [31:0] word_s;
   logic        have_word_s;
   logic        launch_s;

   // Next-state and output computation; a return to FETCH launches the next request at once when issue has room
   always_comb begin
      state_c      = state_r;
      pc_nx        = pc_r;
      ins_nx       = ins_r;
      hold_nx      = hold_r;
      mem_req_c    = mem_req_r;
      mem_addr_c   = mem_addr_r;
      ask_nx       = 1'b0;
      now_addr_nx  = now_addr_r;
      jump_addr_nx = jump_addr_r;
      next_addr_nx = next_addr_r;
      ins_valid_nx = 1'b0;
      ins_out_nx   = ins_out_r;
      ins_pc_nx    = ins_pc_r;
      pred_nx      = pred_r;
      word_s       = hold_r ? ins_r : bus.mem_data;
      have_word_s  = hold_r | bus.mem_valid;

      if (bus.if_flush) begin
         pc_nx     = bus.addr_to_if;
         hold_nx   = 1'b0;
         mem_req_c = 1'b0;
         // An outstanding fetch must still be swallowed before refetching
         if (((state_r == WAIT_MEM) && !hold_r && !bus.mem_valid) ||
             ((state_r == DRAIN) && !bus.mem_valid)) begin
            state_c = DRAIN;
         end else begin
            state_c = FETCH;
         end
      end else begin
         case (state_r)
            FETCH: begin
               state_c = FETCH;
            end
            WAIT_MEM: begin
               if (have_word_s) begin
                  mem_req_c = 1'b0;
                  ins_nx    = word_s;
                  case (word_s[6:0])
                     OP_BRANCH: begin
                        if (!bus.predictor_full) begin
                           ask_nx       = 1'b1;
                           now_addr_nx  = pc_r;
                           jump_addr_nx = pc_r + b_imm(word_s);
                           next_addr_nx = pc_r + 32'd4;
                           hold_nx      = 1'b0;
                           state_c      = WAIT_PRED;
                        end else begin
                           hold_nx = 1'b1;
                           state_c = WAIT_MEM;
                        end
                     end
                     OP_JAL: begin
                        ins_valid_nx = 1'b1;
                        ins_out_nx   = word_s;
                        ins_pc_nx    = pc_r;
                        pred_nx      = 1'b1;
                        pc_nx        = pc_r + j_imm(word_s);
                        state_c      = FETCH;
                     end
                     OP_JALR: begin
                        ins_valid_nx = 1'b1;
                        ins_out_nx   = word_s;
                        ins_pc_nx    = pc_r;
                        pred_nx      = 1'b0;
                        state_c      = WAIT_JALR;
                     end
                     default: begin
                        ins_valid_nx = 1'b1;
                        ins_out_nx   = word_s;
                        ins_pc_nx    = pc_r;
                        pred_nx      = 1'b0;
                        pc_nx        = pc_r + 32'd4;
                        state_c      = FETCH;
                     end
                  endcase
               end else begin
                  state_c = WAIT_MEM;
               end
            end
            WAIT_PRED: begin
               if (bus.predictor_sgn_rdy) begin
                  ins_valid_nx = 1'b1;
                  ins_out_nx   = ins_r;
                  ins_pc_nx    = pc_r;
                  pred_nx      = bus.pred_jump;
                  pc_nx        = bus.pred_jump ? jump_addr_r : next_addr_r;
                  state_c      = FETCH;
               end else begin
                  state_c = WAIT_PRED;
               end
            end
            WAIT_JALR: begin
               if (bus.jalr_done) begin
                  pc_nx   = bus.jalr_target & 32'hFFFF_FFFE;
                  state_c = FETCH;
               end else begin
                  state_c = WAIT_JALR;
               end
            end
            DRAIN: begin
               if (bus.mem_valid) begin
                  state_c = FETCH;
               end else begin
                  state_c = DRAIN;
               end
            end
            default: begin
               state_c   = FETCH;
               mem_req_c = 1'b0;
            end
         endcase
      end

      launch_s    = (state_c == FETCH) && !bus.if_flush && !bus.issue_full;
      state_nx    = launch_s ? WAIT_MEM : state_c;
      mem_req_nx  = launch_s ? 1'b1 : mem_req_c;
      mem_addr_nx = launch_s ? pc_nx : mem_addr_c;
   end

   // State and registered outputs; rdy low freezes everything, pulses included
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= FETCH;
         pc_r        <= RESET_PC;
         ins_r       <= 32'h0;
         hold_r      <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_addr_r  <= 32'h0;
         ask_r       <= 1'b0;
         now_addr_r  <= 32'h0;
         jump_addr_r <= 32'h0;
         next_addr_r <= 32'h0;
         ins_valid_r <= 1'b0;
         ins_out_r   <= 32'h0;
         ins_pc_r    <= 32'h0;
         pred_r      <= 1'b0;
      end else if (rdy) begin
         state_r     <= state_nx;
         pc_r        <= pc_nx;
         ins_r       <= ins_nx;
         hold_r      <= hold_nx;
         mem_req_r   <= mem_req_nx;
         mem_addr_r  <= mem_addr_nx;
         ask_r       <= ask_nx;
         now_addr_r  <= now_addr_nx;
         jump_addr_r <= jump_addr_nx;
         next_addr_r <= next_addr_nx;
         ins_valid_r <= ins_valid_nx;
         ins_out_r   <= ins_out_nx;
         ins_pc_r    <= ins_pc_nx;
         pred_r      <= pred_nx;
      end else begin
         state_r <= state_r;
      end
   end

   assign bus.mem_req           = mem_req_r;
   assign bus.mem_addr          = mem_addr_r;
   assign bus.ask_predictor     = ask_r;
   assign bus.now_ins_addr      = now_addr_r;
   assign bus.jump_addr_to_pred = jump_addr_r;
   assign bus.next_addr_to_pred = next_addr_r;
   assign bus.ins_valid         = ins_valid_r;
   assign bus.ins_out           = ins_out_r;
   assign bus.ins_pc            = ins_pc_r;
   assign bus.ins_pred_jump     = pred_r;
endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher: sequential fetch, branch
// prediction, predictor back-pressure, flush, JAL/JALR, rdy freeze and reset.
module tb_ins_fetcher;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   localparam logic [31:0] ADDI = 32'h0010_0093;
   localparam logic [31:0] BR20 = 32'h0200_0063;
   localparam logic [31:0] JALM8 = 32'hFF9F_F06F;
   localparam logic [31:0] JALR = 32'h0000_8067;

   ins_fetcher_if bus();

   ins_fetcher #(.RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag, input logic [31:0] addr);
      for (int i = 0; i < 20; i++) begin
         if (bus.mem_req) break;
         tick();
      end
      chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
      chk({tag, "_addr"}, bus.mem_addr, addr);
   endtask

   task automatic mem_resp(input logic [31:0] data);
      bus.mem_valid = 1'b1;
      bus.mem_data  = data;
      tick();
      bus.mem_valid = 1'b0;
   endtask

   task automatic verdict(input logic taken);
      bus.predictor_sgn_rdy = 1'b1;
      bus.pred_jump         = taken;
      tick();
      bus.predictor_sgn_rdy = 1'b0;
      bus.pred_jump         = 1'b0;
   endtask

   initial begin
      bus.mem_valid = 1'b0; bus.mem_data = 32'h0; bus.pred_jump = 1'b0;
      bus.predictor_sgn_rdy = 1'b0; bus.predictor_full = 1'b0; bus.if_flush = 1'b0;
      bus.addr_to_if = 32'h0; bus.issue_full = 1'b0; bus.jalr_done = 1'b0;
      bus.jalr_target = 32'h0;
      tick(); tick();
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_ins_valid", {31'd0, bus.ins_valid}, 32'd0);
      chk("rst_ask", {31'd0, bus.ask_predictor}, 32'd0);
      chk("rst_ins_pc", bus.ins_pc, 32'h0);
      rst = 1'b0;
      tick();

      // Sequential fetch of plain instructions
      wait_req("seq0", 32'h0);
      mem_resp(ADDI);
      chk("seq0_valid", {31'd0, bus.ins_valid}, 32'd1);
      chk("seq0_pc", bus.ins_pc, 32'h0);
      chk("seq0_word", bus.ins_out, ADDI);
      wait_req("seq1", 32'h4);
      mem_resp(ADDI);
      chk("seq1_pc", bus.ins_pc, 32'h4);
      wait_req("seq2", 32'h8);
      mem_resp(ADDI);
      chk("seq2_pc", bus.ins_pc, 32'h8);
      wait_req("seq3", 32'hC);
      mem_resp(ADDI);
      tick();
      chk("valid_pulse", {31'd0, bus.ins_valid}, 32'd0);

      // Taken branch at 0x10
      wait_req("br1", 32'h10);
      mem_resp(BR20);
      chk("br1_ask", {31'd0, bus.ask_predictor}, 32'd1);
      chk("br1_now", bus.now_ins_addr, 32'h10);
      chk("br1_jump", bus.jump_addr_to_pred, 32'h30);
      chk("br1_next", bus.next_addr_to_pred, 32'h14);
      chk("br1_novalid", {31'd0, bus.ins_valid}, 32'd0);
      tick();
      chk("br1_ask_pulse", {31'd0, bus.ask_predictor}, 32'd0);
      verdict(1'b1);
      chk("br1_valid", {31'd0, bus.ins_valid}, 32'd1);
      chk("br1_pred", {31'd0, bus.ins_pred_jump}, 32'd1);
      chk("br1_pc", bus.ins_pc, 32'h10);

      // Not-taken branch at 0x30
      wait_req("br2", 32'h30);
      mem_resp(BR20);
      chk("br2_jump", bus.jump_addr_to_pred, 32'h50);
      tick();
      verdict(1'b0);
      chk("br2_pred", {31'd0, bus.ins_pred_jump}, 32'd0);

      // Branch at 0x34 while the predictor is full for three cycles
      wait_req("full", 32'h34);
      bus.predictor_full = 1'b1;
      mem_resp(BR20);
      chk("full_ask0", {31'd0, bus.ask_predictor}, 32'd0);
      tick();
      chk("full_ask1", {31'd0, bus.ask_predictor}, 32'd0);
      tick();
      chk("full_ask2", {31'd0, bus.ask_predictor}, 32'd0);
      bus.predictor_full = 1'b0;
      tick();
      chk("full_ask3", {31'd0, bus.ask_predictor}, 32'd1);
      chk("full_now", bus.now_ins_addr, 32'h34);
      chk("full_jump", bus.jump_addr_to_pred, 32'h54);
      tick();
      chk("full_ask_once", {31'd0, bus.ask_predictor}, 32'd0);
      verdict(1'b0);

      // Flush while waiting on memory; the late word is swallowed
      wait_req("fl1", 32'h38);
      bus.if_flush = 1'b1; bus.addr_to_if = 32'h100;
      tick();
      bus.if_flush = 1'b0;
      chk("fl1_req_drop", {31'd0, bus.mem_req}, 32'd0);
      tick();
      mem_resp(ADDI);
      chk("fl1_novalid", {31'd0, bus.ins_valid}, 32'd0);
      wait_req("fl1_refetch", 32'h100);

      // Flush in the same cycle as the verdict
      mem_resp(BR20);
      tick();
      bus.if_flush = 1'b1; bus.addr_to_if = 32'h100;
      verdict(1'b1);
      bus.if_flush = 1'b0;
      chk("fl2_novalid", {31'd0, bus.ins_valid}, 32'd0);
      wait_req("fl2", 32'h100);

      // Flush coinciding with mem_valid discards the word, then JAL at 0x40
      bus.if_flush = 1'b1; bus.addr_to_if = 32'h40;
      mem_resp(ADDI);
      bus.if_flush = 1'b0;
      chk("fl3_novalid", {31'd0, bus.ins_valid}, 32'd0);
      wait_req("jal", 32'h40);
      mem_resp(JALM8);
      chk("jal_valid", {31'd0, bus.ins_valid}, 32'd1);
      chk("jal_pred", {31'd0, bus.ins_pred_jump}, 32'd1);
      chk("jal_pc", bus.ins_pc, 32'h40);

      // JALR stalls fetch until its target is resolved
      wait_req("jalr", 32'h38);
      mem_resp(JALR);
      chk("jalr_valid", {31'd0, bus.ins_valid}, 32'd1);
      chk("jalr_pred", {31'd0, bus.ins_pred_jump}, 32'd0);
      tick(); tick(); tick();
      chk("jalr_stall", {31'd0, bus.mem_req}, 32'd0);
      bus.jalr_done = 1'b1; bus.jalr_target = 32'h201;
      tick();
      bus.jalr_done = 1'b0;
      wait_req("jalr_tgt", 32'h200);

      // rdy low freezes the request and holds a delivered pulse
      rdy = 1'b0;
      tick(); tick();
      chk("rdy_hold_req", {31'd0, bus.mem_req}, 32'd1);
      rdy = 1'b1;
      mem_resp(ADDI);
      rdy = 1'b0;
      tick();
      chk("rdy_hold_valid", {31'd0, bus.ins_valid}, 32'd1);
      chk("rdy_hold_pc", bus.ins_pc, 32'h200);
      rdy = 1'b1;
      tick();
      chk("rdy_release", {31'd0, bus.ins_valid}, 32'd0);

      // Reset mid-transaction; a late mem_valid is ignored
      rst = 1'b1;
      tick();
      chk("rst2_req", {31'd0, bus.mem_req}, 32'd0);
      rst = 1'b0;
      mem_resp(ADDI);
      chk("rst2_novalid", {31'd0, bus.ins_valid}, 32'd0);
      wait_req("rst2", 32'h0);

      // issue_full blocks new requests
      mem_resp(ADDI);
      bus.issue_full = 1'b1;
      wait_req("ifull_pre", 32'h4);
      mem_resp(ADDI);
      tick(); tick();
      chk("ifull_block", {31'd0, bus.mem_req}, 32'd0);
      bus.issue_full = 1'b0;
      tick();
      wait_req("ifull_go", 32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
